adsr_envelope: RTL and testbench

//   Per-voice ADSR amplitude envelope stage, directly downstream of the oscillator.

---
 rtl/adsr_envelope.sv | 182 ++++++++++++++++++
 tb/tb_adsr_envelope.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: scales the oscillator sample by a gate-driven 16-bit envelope.
// Define ADSR_VELOCITY_EN for a latched-velocity second gain stage (latency becomes 2 cycles).
module adsr_envelope #(
  parameter int WIDTH = 24,
  parameter int ENV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sample,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] decay_rate,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic [ENV_W-1:0] release_rate,
  input  logic [6:0]       velocity,
  output logic [WIDTH-1:0] out_sample,
  output logic             out_valid,
  output logic             busy
);

  localparam int PW = WIDTH + ENV_W;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic             gate_q, gate_d;
  logic [WIDTH-1:0] out_sample_q, out_sample_d;
  logic             out_valid_q, out_valid_d;

  logic             rise;
  logic [ENV_W:0]   att_sum;
  logic [ENV_W:0]   dec_thr;
  state_t           att_state;
  logic [ENV_W-1:0] att_env;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] scaled;

  assign rise    = gate & ~gate_q;
  assign att_sum = {1'b0, env_q} + {1'b0, attack_rate};
  assign dec_thr = {1'b0, sustain_level} + {1'b0, decay_rate};
  assign prod    = PW'(in_sample) * PW'(env_q);
  assign scaled  = prod[PW-1:ENV_W];

  // One attack step, shared by ATTACK and by a retrigger from IDLE/RELEASE on the same tick.
  always_comb begin
    att_state = ST_ATTACK;
    att_env   = att_sum[ENV_W-1:0];
    if (att_sum >= {1'b0, ENV_MAX}) begin
      att_state = ST_DECAY;
      att_env   = ENV_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    gate_d  = gate_q;
    if (in_valid) begin
      gate_d = gate;
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = att_state;
            env_d   = att_env;
          end else begin
            env_d = '0;
          end
        end
        ST_RELEASE: begin
          if (rise) begin
            state_d = att_state;
            env_d   = att_env;
          end else if (env_q <= release_rate) begin
            state_d = ST_IDLE;
            env_d   = '0;
          end else begin
            env_d = env_q - release_rate;
          end
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = att_state;
            env_d   = att_env;
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else if ({1'b0, env_q} <= dec_thr) begin
            state_d = ST_SUSTAIN;
            env_d   = sustain_level;
          end else begin
            env_d = env_q - decay_rate;
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else begin
            env_d = sustain_level;
          end
        end
        default: begin
          state_d = ST_IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

`ifdef ADSR_VELOCITY_EN
  logic [6:0]       vel_q, vel_d;
  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic             stage1_valid_q, stage1_valid_d;
  logic [7:0]       vel_mult;
  logic [WIDTH+7:0] prod2;

  assign vel_mult = {1'b0, vel_q} + 8'd1;
  assign prod2    = (WIDTH + 8)'(stage1_q) * (WIDTH + 8)'(vel_mult);

  always_comb begin
    vel_d          = vel_q;
    stage1_d       = stage1_q;
    stage1_valid_d = in_valid;
    out_sample_d   = out_sample_q;
    out_valid_d    = stage1_valid_q;
    if (in_valid && rise) vel_d = velocity;
    if (in_valid) stage1_d = scaled;
    if (stage1_valid_q) out_sample_d = prod2[WIDTH+6:7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vel_q          <= '0;
      stage1_q       <= '0;
      stage1_valid_q <= 1'b0;
    end else begin
      vel_q          <= vel_d;
      stage1_q       <= stage1_d;
      stage1_valid_q <= stage1_valid_d;
    end
  end
`else
  always_comb begin
    out_sample_d = out_sample_q;
    out_valid_d  = in_valid;
    if (in_valid) out_sample_d = scaled;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      env_q        <= '0;
      gate_q       <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      env_q        <= env_d;
      gate_q       <= gate_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope walk-through plus randomized run against a phase/level model.
module tb_adsr_envelope;

  localparam int WIDTH = 24;
  localparam int ENV_W = 16;
  localparam longint unsigned EMAX = 64'd65535;

  logic             clk;
  logic             rst;
  logic             gate;
  logic             in_valid;
  logic [WIDTH-1:0] in_sample;
  logic [ENV_W-1:0] attack_rate;
  logic [ENV_W-1:0] decay_rate;
  logic [ENV_W-1:0] sustain_level;
  logic [ENV_W-1:0] release_rate;
  logic [6:0]       velocity;
  logic [WIDTH-1:0] out_sample;
  logic             out_valid;
  logic             busy;

  adsr_envelope #(.WIDTH(WIDTH), .ENV_W(ENV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .gate         (gate),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .velocity     (velocity),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: envelope phase as a name and level as a plain integer.
  string           m_phase;
  longint unsigned m_env;
  bit              m_gate;
  longint unsigned m_out;
  bit              m_valid;
  longint unsigned m_s1;
  bit              m_s1_valid;
  longint unsigned m_vel;

  function automatic void model_reset();
    m_phase    = "IDLE";
    m_env      = 0;
    m_gate     = 0;
    m_out      = 0;
    m_valid    = 0;
    m_s1       = 0;
    m_s1_valid = 0;
    m_vel      = 0;
  endfunction

  function automatic void model_step();
    longint unsigned prior_env;
    longint unsigned gain;
    bit              rising;
    bit              held;
    if (rst) begin
      model_reset();
      return;
    end
    prior_env = m_env;
    gain = (longint'(in_sample) * prior_env) / 65536;
    rising = in_valid && gate && !m_gate;
`ifdef ADSR_VELOCITY_EN
    if (m_s1_valid) m_out = (m_s1 * (m_vel + 1)) / 128;
    m_valid    = m_s1_valid;
    if (in_valid) m_s1 = gain;
    m_s1_valid = in_valid;
    if (rising) m_vel = velocity;
`else
    if (in_valid) m_out = gain;
    m_valid = in_valid;
`endif
    if (!in_valid) return;
    m_gate = gate;
    held = 0;
    if (rising && (m_phase == "IDLE" || m_phase == "RELEASE")) begin
      m_phase = "ATTACK";
    end else if (!gate && (m_phase == "ATTACK" || m_phase == "DECAY" || m_phase == "SUSTAIN")) begin
      m_phase = "RELEASE";
      held = 1;
    end
    if (held) return;
    if (m_phase == "IDLE") begin
      m_env = 0;
    end else if (m_phase == "ATTACK") begin
      if (m_env + attack_rate >= EMAX) begin
        m_env = EMAX;
        m_phase = "DECAY";
      end else begin
        m_env = m_env + attack_rate;
      end
    end else if (m_phase == "DECAY") begin
      if (m_env <= longint'(sustain_level) + decay_rate) begin
        m_env = sustain_level;
        m_phase = "SUSTAIN";
      end else begin
        m_env = m_env - decay_rate;
      end
    end else if (m_phase == "SUSTAIN") begin
      m_env = sustain_level;
    end else begin
      if (m_env <= release_rate) begin
        m_env = 0;
        m_phase = "IDLE";
      end else begin
        m_env = m_env - release_rate;
      end
    end
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val({tag, ".out_valid"},  64'(out_valid),  64'(m_valid));
    check_val({tag, ".busy"},       64'(busy),       64'(m_phase != "IDLE"));
    check_val({tag, ".out_sample"}, 64'(out_sample), m_out);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    model_reset();
    rst = 1; gate = 0; in_valid = 0; in_sample = '1;
    attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
    velocity = 7'd63;

    // reset with in_valid toggling
    for (int i = 0; i < 2; i++) begin
      in_valid = (i == 0);
      tick("reset");
    end
    check_val("reset.busy_const", 64'(busy), 64'd0);
    check_val("reset.out_const", 64'(out_sample), 64'd0);

    // attack from reset with gate already high
    rst = 0; in_valid = 1; gate = 1; attack_rate = 16'h4000;
    ticks("attack", 4);
    check_val("attack.phase", 64'(m_phase == "DECAY"), 64'd1);

    // decay stalled at full scale; raw gain check
    decay_rate = '0; in_sample = 24'h800000;
    tick("full1");
`ifndef ADSR_VELOCITY_EN
    check_val("full.gain_const", 64'(out_sample), 64'h7FFF80);
`endif
    tick("full2");
`ifdef ADSR_VELOCITY_EN
    check_val("full.vel_const", 64'(out_sample), 64'h3FFFC0);
`endif

    // decay into sustain, then live sustain tracking
    in_sample = '1; decay_rate = 16'h1000; sustain_level = 16'h8000;
    ticks("decay", 8);
    sustain_level = 16'h6000;
    ticks("sustain_live", 2);
    sustain_level = 16'h8000;
    ticks("sustain", 2);

    // release to idle
    gate = 0; release_rate = 16'h2000;
    ticks("release", 5);
    check_val("release.busy_const", 64'(busy), 64'd0);

    // retrigger in release, then freeze with in_valid low
    gate = 1; attack_rate = 16'h4000;
    tick("note2");
    gate = 0;
    tick("note2_off");
    gate = 1; attack_rate = 16'h1000;
    ticks("retrig", 2);
    in_valid = 0;
    ticks("freeze", 10);
    in_valid = 1;
    ticks("thaw", 3);

    // randomized run
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sample = WIDTH'($urandom);
      velocity = 7'($urandom);
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 149) == 0) begin
        attack_rate  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
        decay_rate   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000));
        release_rate = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000));
      end
      if ($urandom_range(0, 59) == 0)
        sustain_level = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 299) == 0) attack_rate = 16'hFFFF;
      tick("rand");
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
